// File: rtl/dmem_bus_pkg.sv
// Shared encodings for the data-memory bus controller: access sizes, FSM
// states and the wait-state counter width.
package dmem_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: byte enables, store-data replication,
// load-lane extraction and natural-alignment check for one access.
module dmem_lane_fmt
  import dmem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        aligned
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'b0;
    rdata_ext = 32'b0;
    aligned   = 1'b0;
    case (size)
      SZ_BYTE: begin
        aligned   = 1'b1;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'b0, rdata[{addr_lo, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        aligned   = ~addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'b0, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
      end
      SZ_WORD: begin
        aligned   = (addr_lo == 2'b00);
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      // SIZE=11 is never aligned, so it is always rejected.
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller between the core data port and a single-port
// synchronous SRAM. Optional access counters are built with DMEM_STATS_EN.
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int MEM_AW      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ,
  input  logic              WRITE,
  input  logic [1:0]        SIZE,
  input  logic [31:0]       DAD,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              ACKD_n,
  output logic              bus_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef DMEM_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_err,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: MREQ is sampled only in IDLE; once taken the transfer always
  // completes with exactly one ACKD_n=0 cycle (bus_err qualifies that cycle),
  // and MREQ/DAD are ignored until the controller is back in IDLE.

  state_e              state;
  logic [WAIT_CW-1:0]  wait_cnt;
  logic                req_wr;
  logic                req_err;
  logic [1:0]          req_size;
  logic [1:0]          req_lo;
  logic [MEM_AW-1:0]   req_waddr;
  logic [31:0]         req_wdata;

  logic [1:0]  fmt_size;
  logic [1:0]  fmt_lo;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;
  logic        fmt_aligned;
  logic        in_range;
  logic        req_ok;

  // The formatter checks the live request in IDLE and serves the latched one afterwards.
  assign fmt_size = (state == ST_IDLE) ? SIZE     : req_size;
  assign fmt_lo   = (state == ST_IDLE) ? DAD[1:0] : req_lo;

  dmem_lane_fmt u_fmt (
    .size      (fmt_size),
    .addr_lo   (fmt_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (fmt_be),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .aligned   (fmt_aligned)
  );

  assign in_range = ((DAD >> (MEM_AW + 2)) == 32'd0);
  assign req_ok   = fmt_aligned & in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ACKD_n    <= 1'b1;
      bus_err   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      wait_cnt  <= '0;
      req_wr    <= 1'b0;
      req_err   <= 1'b0;
      req_size  <= SZ_BYTE;
      req_lo    <= 2'b00;
      req_waddr <= '0;
      req_wdata <= 32'b0;
    end else begin
      ACKD_n  <= 1'b1;
      bus_err <= 1'b0;
      mem_cs  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MREQ) begin
            req_wr    <= WRITE;
            req_size  <= SIZE;
            req_lo    <= DAD[1:0];
            req_waddr <= DAD[MEM_AW+1:2];
            req_wdata <= core_wdata;
            req_err   <= ~req_ok;
            if (req_ok) begin
              state  <= ST_ACCESS;
              mem_cs <= 1'b1;
              mem_we <= WRITE;
            end else begin
              state   <= ST_ACK;
              ACKD_n  <= 1'b0;
              bus_err <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (WAIT_CYCLES == 0) begin
            state   <= ST_ACK;
            ACKD_n  <= 1'b0;
            bus_err <= req_err;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_CW'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_CW'(1)) begin
            state   <= ST_ACK;
            ACKD_n  <= 1'b0;
            bus_err <= req_err;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_be     = mem_cs ? fmt_be    : 4'b0000;
  assign mem_wdata  = mem_cs ? fmt_wdata : 32'b0;
  assign mem_addr   = req_waddr;
  // SRAM holds its read data while deselected, so the ACK cycle can use it directly.
  assign core_rdata = (state == ST_ACK && !req_wr && !req_err) ? fmt_rdata : 32'b0;
  assign dbg_state  = state;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd  <= 32'b0;
      stat_wr  <= 32'b0;
      stat_err <= 32'b0;
    end else if (stat_clr) begin
      stat_rd  <= 32'b0;
      stat_wr  <= 32'b0;
      stat_err <= 32'b0;
    end else if (state == ST_ACK) begin
      if (req_err)     stat_err <= stat_err + 32'd1;
      else if (req_wr) stat_wr  <= stat_wr + 32'd1;
      else             stat_rd  <= stat_rd + 32'd1;
    end
  end
`endif

endmodule
